// File: rtl/ddrdll_update_sequencer.sv
// DDRDLL reset/lock/update sequencer: brings one DLL to lock, publishes its
// delay code and refreshes it through FREEZE/UDDCNTL_N update pulses.
module ddrdll_update_sequencer #(
  parameter int CODE_W       = 9,
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_FILT    = 4,
  parameter int LOCK_TIMEOUT = 4096,
  parameter int UPD_INTERVAL = 1024,
  parameter int FREEZE_SETUP = 4,
  parameter int UPD_PULSE    = 2,
  parameter int SETTLE       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              upd_req,
  output logic              upd_ack,
  output logic              busy,
  output logic              lock_err,
  output logic              code_valid,
  output logic [CODE_W-1:0] code_out,
  output logic              dll_rst,
  output logic              dll_freeze,
  output logic              dll_uddcntl_n,
  input  logic              dll_lock,
  input  logic [CODE_W-1:0] dll_code
);

  localparam int M1 = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int M2 = (UPD_INTERVAL > FREEZE_SETUP) ? UPD_INTERVAL : FREEZE_SETUP;
  localparam int M3 = (UPD_PULSE > SETTLE) ? UPD_PULSE : SETTLE;
  localparam int M4 = (M1 > M2) ? M1 : M2;
  localparam int MAXP = (M4 > M3) ? M4 : M3;
  localparam int CW = $clog2(MAXP + 1);
  localparam int FW = $clog2(LOCK_FILT + 1);

  typedef enum logic [2:0] {
    S_OFF, S_RST, S_LOCK, S_IDLE, S_FRZ, S_UPD, S_SETTLE
  } state_t;

  state_t            state, state_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [FW-1:0]     filt, filt_n;
  logic [FW-1:0]     filt_inc;
  logic              pending, pending_n;
  logic              valid_n, err_n, ack_n;
  logic [CODE_W-1:0] code_n;
  logic              last, filt_full, trig;

  assign last      = (cnt == CW'(1));
  assign filt_inc  = filt + FW'(1);
  assign filt_full = (filt_inc == FW'(LOCK_FILT));
  assign trig      = upd_req || pending ||
                     ((UPD_INTERVAL != 0) && last);

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    filt_n    = filt;
    pending_n = pending || upd_req;
    valid_n   = code_valid;
    err_n     = lock_err;
    ack_n     = 1'b0;
    code_n    = code_out;
    if (!en) begin
      state_n   = S_OFF;
      cnt_n     = '0;
      filt_n    = '0;
      pending_n = 1'b0;
      valid_n   = 1'b0;
      code_n    = '0;
    end else begin
      unique case (state)
        S_OFF: begin
          state_n = S_RST;
          cnt_n   = CW'(RST_CYCLES);
          filt_n  = '0;
        end
        S_RST: begin
          valid_n = 1'b0;
          if (last) begin
            state_n = S_LOCK;
            cnt_n   = CW'(LOCK_TIMEOUT);
            filt_n  = '0;
          end else begin
            cnt_n = cnt - CW'(1);
          end
        end
        S_LOCK: begin
          filt_n = dll_lock ? filt_inc : '0;
          // acceptance beats a simultaneous timeout
          if (dll_lock && filt_full) begin
            state_n = S_IDLE;
            code_n  = dll_code;
            valid_n = 1'b1;
            cnt_n   = CW'(UPD_INTERVAL);
            filt_n  = '0;
          end else if (last) begin
            state_n = S_RST;
            err_n   = 1'b1;
            cnt_n   = CW'(RST_CYCLES);
            filt_n  = '0;
          end else begin
            cnt_n = cnt - CW'(1);
          end
        end
        S_IDLE: begin
          if (!dll_lock && filt_full) begin
            state_n = S_RST;
            valid_n = 1'b0;
            cnt_n   = CW'(RST_CYCLES);
            filt_n  = '0;
          end else if (trig) begin
            state_n   = S_FRZ;
            cnt_n     = CW'(FREEZE_SETUP);
            filt_n    = '0;
            pending_n = 1'b0;
          end else begin
            filt_n = dll_lock ? '0 : filt_inc;
            if (UPD_INTERVAL != 0) cnt_n = cnt - CW'(1);
          end
        end
        S_FRZ: begin
          if (last) begin
            state_n = S_UPD;
            cnt_n   = CW'(UPD_PULSE);
          end else begin
            cnt_n = cnt - CW'(1);
          end
        end
        S_UPD: begin
          if (last) begin
            state_n = S_SETTLE;
            cnt_n   = CW'(SETTLE);
          end else begin
            cnt_n = cnt - CW'(1);
          end
        end
        S_SETTLE: begin
          if (last) begin
            state_n = S_IDLE;
            code_n  = dll_code;
            ack_n   = 1'b1;
            cnt_n   = CW'(UPD_INTERVAL);
            filt_n  = '0;
          end else begin
            cnt_n = cnt - CW'(1);
          end
        end
        default: state_n = S_OFF;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_OFF;
      cnt           <= '0;
      filt          <= '0;
      pending       <= 1'b0;
      code_valid    <= 1'b0;
      code_out      <= '0;
      lock_err      <= 1'b0;
      upd_ack       <= 1'b0;
      busy          <= 1'b0;
      dll_rst       <= 1'b1;
      dll_freeze    <= 1'b0;
      dll_uddcntl_n <= 1'b1;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      filt          <= filt_n;
      pending       <= pending_n;
      code_valid    <= valid_n;
      code_out      <= code_n;
      lock_err      <= err_n;
      upd_ack       <= ack_n;
      busy          <= (state_n != S_OFF) && (state_n != S_IDLE);
      dll_rst       <= (state_n == S_OFF) || (state_n == S_RST);
      dll_freeze    <= (state_n == S_FRZ) || (state_n == S_UPD) ||
                       (state_n == S_SETTLE);
      dll_uddcntl_n <= (state_n != S_UPD);
    end
  end

endmodule

// File: tb/tb_ddrdll_update_sequencer.sv
// Randomized scoreboard bench for ddrdll_update_sequencer: a phase/age
// reference model queues expected outputs, a monitor compares each cycle.
module tb_ddrdll_update_sequencer;

  localparam int CW   = 9;
  localparam int RSTC = 16;
  localparam int LF   = 4;
  localparam int TO   = 64;
  localparam int INTV = 100;
  localparam int FS   = 4;
  localparam int UP   = 2;
  localparam int ST   = 8;
  localparam int ULEN = FS + UP + ST;

  localparam int P_OFF  = 0;
  localparam int P_RST  = 1;
  localparam int P_LOCK = 2;
  localparam int P_IDLE = 3;
  localparam int P_UPD  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, en, upd_req, dll_lock;
  logic [CW-1:0] dll_code;
  logic          upd_ack, busy, lock_err, code_valid;
  logic [CW-1:0] code_out;
  logic          dll_rst, dll_freeze, dll_uddcntl_n;

  ddrdll_update_sequencer #(
    .CODE_W(CW), .RST_CYCLES(RSTC), .LOCK_FILT(LF),
    .LOCK_TIMEOUT(TO), .UPD_INTERVAL(INTV),
    .FREEZE_SETUP(FS), .UPD_PULSE(UP), .SETTLE(ST)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .upd_req(upd_req),
    .upd_ack(upd_ack), .busy(busy), .lock_err(lock_err),
    .code_valid(code_valid), .code_out(code_out),
    .dll_rst(dll_rst), .dll_freeze(dll_freeze),
    .dll_uddcntl_n(dll_uddcntl_n),
    .dll_lock(dll_lock), .dll_code(dll_code)
  );

  typedef struct packed {
    logic          r, f, u, b, e, v, a;
    logic [CW-1:0] c;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;

  // reference model: phase, time spent in phase, run lengths of dll_lock
  int ph = P_OFF;
  int age = 0;
  int hirun = 0;
  int lorun = 0;
  bit pend = 0;
  bit m_err = 0;
  bit m_cv = 0;
  bit m_ack = 0;
  logic [CW-1:0] m_code = '0;

  always @(posedge clk) begin
    exp_t x;
    m_ack = 0;
    if (rst) begin
      ph = P_OFF; age = 0; hirun = 0; lorun = 0;
      pend = 0; m_err = 0; m_cv = 0; m_code = '0;
    end else if (!en) begin
      ph = P_OFF; age = 0; pend = 0; m_cv = 0; m_code = '0;
    end else begin
      case (ph)
        P_OFF: begin
          pend = pend | upd_req;
          ph = P_RST; age = 0;
        end
        P_RST: begin
          pend = pend | upd_req;
          age++;
          if (age == RSTC) begin ph = P_LOCK; age = 0; hirun = 0; end
        end
        P_LOCK: begin
          pend = pend | upd_req;
          hirun = dll_lock ? hirun + 1 : 0;
          age++;
          if (hirun == LF) begin
            m_code = dll_code; m_cv = 1;
            ph = P_IDLE; age = 0; lorun = 0;
          end else if (age == TO) begin
            m_err = 1; ph = P_RST; age = 0;
          end
        end
        P_IDLE: begin
          lorun = dll_lock ? 0 : lorun + 1;
          age++;
          if (lorun == LF) begin
            pend = pend | upd_req;
            m_cv = 0; ph = P_RST; age = 0;
          end else if (upd_req || pend || age == INTV) begin
            pend = 0; ph = P_UPD; age = 0;
          end
        end
        default: begin
          pend = pend | upd_req;
          age++;
          if (age == ULEN) begin
            m_code = dll_code; m_ack = 1;
            ph = P_IDLE; age = 0; lorun = 0;
          end
        end
      endcase
    end
    x.r = (ph == P_OFF) || (ph == P_RST);
    x.f = (ph == P_UPD);
    x.u = !((ph == P_UPD) && age >= FS && age < FS + UP);
    x.b = (ph != P_OFF) && (ph != P_IDLE);
    x.e = m_err;
    x.v = m_cv;
    x.a = m_ack;
    x.c = m_code;
    q.push_back(x);
  end

  task automatic chk(input string n, input logic [CW-1:0] a,
                     input logic [CW-1:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s t=%0t got=%h exp=%h", n, $time, a, e);
    end
  endtask

  always @(negedge clk) begin
    exp_t x;
    if (q.size() > 0) begin
      x = q.pop_front();
      chk("dll_rst", CW'(dll_rst), CW'(x.r));
      chk("dll_freeze", CW'(dll_freeze), CW'(x.f));
      chk("dll_uddcntl_n", CW'(dll_uddcntl_n), CW'(x.u));
      chk("busy", CW'(busy), CW'(x.b));
      chk("lock_err", CW'(lock_err), CW'(x.e));
      chk("code_valid", CW'(code_valid), CW'(x.v));
      chk("upd_ack", CW'(upd_ack), CW'(x.a));
      chk("code_out", code_out, x.c);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_ph(input int p, input int lim);
    for (int i = 0; i < lim && ph != p; i++) @(negedge clk);
    total++;
    if (ph != p) begin
      bad++;
      $display("FAIL wait_phase got=%0d exp=%0d", ph, p);
    end
  endtask

  task automatic pulse_req();
    upd_req = 1'b1;
    cyc(1);
    upd_req = 1'b0;
  endtask

  initial begin
    int mode, len, glitch, en_hold;
    rst = 1'b1; en = 1'b0; upd_req = 1'b0;
    dll_lock = 1'b0; dll_code = 9'h0A5;
    cyc(2);
    rst = 1'b0; en = 1'b1;
    // bring-up and lock
    cyc(18);
    dll_lock = 1'b1;
    cyc(40);
    // requested update
    dll_code = 9'h123;
    pulse_req();
    cyc(30);
    // periodic updates plus a request merged during an update
    wait_ph(P_UPD, 200);
    pulse_req();
    pulse_req();
    cyc(250);
    // lock glitch of 3, then loss of 4+
    dll_lock = 1'b0; cyc(3); dll_lock = 1'b1; cyc(10);
    dll_lock = 1'b0; cyc(6); dll_lock = 1'b1;
    cyc(60);
    // timeouts with retries, then lock
    dll_lock = 1'b0; cyc(200);
    dll_code = 9'h05A; dll_lock = 1'b1; cyc(40);
    // disable mid-pulse
    pulse_req();
    wait_ph(P_UPD, 40);
    cyc(FS);
    en = 1'b0; cyc(3); en = 1'b1;
    cyc(60);
    // random segments
    glitch = 0; en_hold = 0;
    for (int s = 0; s < 40; s++) begin
      mode = $urandom_range(0, 2);
      len = $urandom_range(20, 300);
      for (int i = 0; i < len; i++) begin
        if (mode == 0) dll_lock = 1'b1;
        else if (mode == 1) dll_lock = 1'b0;
        else if (glitch > 0) begin
          dll_lock = 1'b0; glitch--;
        end else begin
          dll_lock = 1'b1;
          if ($urandom_range(0, 14) == 0) glitch = $urandom_range(1, 5);
        end
        dll_code = CW'($urandom);
        upd_req = ($urandom_range(0, 39) == 0);
        if (en_hold > 0) begin
          en_hold--;
          en = (en_hold == 0);
        end else if ($urandom_range(0, 599) == 0) begin
          en = 1'b0; en_hold = $urandom_range(1, 4);
        end
        rst = ($urandom_range(0, 2999) == 0);
        cyc(1);
      end
    end
    rst = 1'b0; en = 1'b1; upd_req = 1'b0;
    cyc(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
